// File: rtl/reg_shift_seq.sv
// reg_shift_seq: sequencer for an external universal shift register.
// Accepts one word at a time. It issues a parallel load, then NBITS shift
// strobes spaced DIV clocks apart, then pulses DONE for one cycle.
//
// Ports:
//   CLOCK, RESET  clock and synchronous active-high reset
//   IN_DATA       word to load into the downstream register
//   IN_VALID      IN_DATA/DIR/NBITS are valid
//   IN_READY      block can accept a word this cycle (IDLE only)
//   DIR           0 = shift MSB<LSB (CTRL 01), 1 = shift MSB>LSB (CTRL 11)
//   NBITS         shifts after the load; 0 or above WIDTH means WIDTH
//   SER_IN        asynchronous serial line, synchronised onto S_OUT
//   CTRL          00 hold, 01 shift MSB<LSB, 10 load, 11 shift MSB>LSB
//   D_OUT         parallel-load word (last accepted word)
//   S_OUT         synchronised serial-in bit for the register
//   REG_EN        clock enable for the register
//   BUSY          high in every state except IDLE
//   DONE          one-cycle pulse in the FIN state
//   DBG_STATE_O   current FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 FIN)
//
// Handshake: a word transfers on a rising edge where IN_VALID=1 and
// IN_READY=1 and RESET=0. IN_READY does not depend on IN_VALID, and
// IN_VALID is ignored while IN_READY is low.
module reg_shift_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             DIR,
  input  logic [3:0]       NBITS,
  input  logic             SER_IN,
  output logic [1:0]       CTRL,
  output logic [WIDTH-1:0] D_OUT,
  output logic             S_OUT,
  output logic             REG_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       DBG_STATE_O
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0] PRESC_MAX = 8'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    nbits_q, nbits_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       presc_q, presc_d;
  logic             sync1_q, sync2_q;
  logic             strobe;

  // A strobe is the last cycle of each DIV-long prescaler period; with
  // DIV=1 PRESC_MAX is 0, so every SHIFT cycle is a strobe.
  assign strobe = (state_q == S_SHIFT) && (presc_q == PRESC_MAX);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      nbits_q <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      nbits_q <= nbits_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      sync1_q <= SER_IN;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    nbits_d = nbits_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          data_d = IN_DATA;
          dir_d  = DIR;
          // Out-of-range counts collapse to a full-word shift.
          if ((NBITS == 4'd0) || (int'(NBITS) > WIDTH)) begin
            nbits_d = CW'(WIDTH);
          end else begin
            nbits_d = CW'(NBITS);
          end
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        presc_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (strobe) begin
          presc_d = '0;
          cnt_d   = cnt_q + CW'(1);
          if ((cnt_q + CW'(1)) == nbits_q) begin
            state_d = S_FIN;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    CTRL   = 2'b00;
    REG_EN = 1'b0;
    if (state_q == S_LOAD) begin
      CTRL   = 2'b10;
      REG_EN = 1'b1;
    end else if (strobe) begin
      CTRL   = dir_q ? 2'b11 : 2'b01;
      REG_EN = 1'b1;
    end
  end

  assign IN_READY    = (state_q == S_IDLE);
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = (state_q == S_FIN);
  assign D_OUT       = data_q;
  assign S_OUT       = sync2_q;
  assign DBG_STATE_O = state_q;

endmodule

// File: tb/tb_reg_shift_seq.sv
// Bench for reg_shift_seq. Three instances (DIV = 4, 1, 2) share the same
// stimulus. Each is checked every cycle against a timeline model. The model
// knows only the accept time, NBITS and DIV. A downstream shift register,
// clocked from each DUT's real outputs, checks the end-to-end data effect.
module tb_reg_shift_seq;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       dir;
  logic       ser_in;
  logic [7:0] in_data;
  logic [3:0] nbits;

  logic       in_ready_w [ND];
  logic       reg_en_w   [ND];
  logic       busy_w     [ND];
  logic       done_w     [ND];
  logic       s_out_w    [ND];
  logic [1:0] ctrl_w     [ND];
  logic [1:0] dbg_w      [ND];
  logic [7:0] d_out_w    [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    reg_shift_seq #(
      .WIDTH(8),
      .DIV  ((g == 0) ? 4 : ((g == 1) ? 1 : 2))
    ) u_dut (
      .CLOCK      (clk),
      .RESET      (rst),
      .IN_DATA    (in_data),
      .IN_VALID   (in_valid),
      .IN_READY   (in_ready_w[g]),
      .DIR        (dir),
      .NBITS      (nbits),
      .SER_IN     (ser_in),
      .CTRL       (ctrl_w[g]),
      .D_OUT      (d_out_w[g]),
      .S_OUT      (s_out_w[g]),
      .REG_EN     (reg_en_w[g]),
      .BUSY       (busy_w[g]),
      .DONE       (done_w[g]),
      .DBG_STATE_O(dbg_w[g])
    );
  end

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         m_busy [ND];
  int         m_t    [ND];   // cycles since the accept edge (1 = LOAD)
  int         m_n    [ND];
  bit         m_dir  [ND];
  logic [7:0] m_d    [ND];
  logic       m_h1 = 1'b0;
  logic       m_h2 = 1'b0;
  logic [7:0] dreg   [ND];   // downstream register driven by DUT outputs
  logic [1:0] pc_ctrl[ND];
  logic       pc_en  [ND];
  logic [7:0] pc_d   [ND];
  logic       pc_s   [ND];
  int         strobes[ND];
  logic [1:0] last_code[ND];
  int         done_cyc[ND];
  int         acc2[$];

  function automatic int div_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, i, cyc, act, exp_v);
    end
  endtask

  // Expected outputs from the position in the timeline.
  // t=1 is LOAD; a strobe falls every DIV cycles after it; FIN is at t=2+N*DIV.
  task automatic expect_out(input int i, output logic [1:0] c, output logic en,
                            output logic rdy, output logic bsy, output logic dn);
    int d;
    int last;
    c = 2'b00; en = 1'b0; rdy = !m_busy[i]; bsy = m_busy[i]; dn = 1'b0;
    d = div_of(i);
    last = 2 + m_n[i] * d;
    if (m_busy[i]) begin
      if (m_t[i] == 1) begin
        c = 2'b10; en = 1'b1;
      end else if (m_t[i] == last) begin
        dn = 1'b1;
      end else if (((m_t[i] - 1) % d) == 0) begin
        c = m_dir[i] ? 2'b11 : 2'b01; en = 1'b1;
      end
    end
  endtask

  // One clock: update the model at the edge, then check 1 time unit later.
  task automatic step();
    logic [1:0] c;
    logic en, rdy, bsy, dn;
    @(posedge clk);
    for (int i = 0; i < ND; i++) begin
      if (pc_en[i] === 1'b1) begin
        case (pc_ctrl[i])
          2'b10: dreg[i] = pc_d[i];
          2'b01: dreg[i] = {dreg[i][6:0], pc_s[i]};
          2'b11: dreg[i] = {pc_s[i], dreg[i][7:1]};
          default: ;
        endcase
      end
      if (rst) begin
        m_busy[i] = 1'b0;
        m_d[i]    = 8'h00;
      end else if (m_busy[i]) begin
        if (m_t[i] == 2 + m_n[i] * div_of(i)) m_busy[i] = 1'b0;
        else m_t[i]++;
      end else if (in_valid) begin
        m_busy[i] = 1'b1;
        m_t[i]    = 1;
        m_dir[i]  = dir;
        m_d[i]    = in_data;
        m_n[i]    = ((nbits == 4'd0) || (nbits > 4'd8)) ? 8 : int'(nbits);
      end
    end
    if (rst) begin
      m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      m_h2 = m_h1; m_h1 = ser_in;
    end
    cyc++;
    #1;
    for (int i = 0; i < ND; i++) begin
      expect_out(i, c, en, rdy, bsy, dn);
      chk("ctrl", i, 32'(ctrl_w[i]), 32'(c));
      chk("reg_en", i, 32'(reg_en_w[i]), 32'(en));
      chk("in_ready", i, 32'(in_ready_w[i]), 32'(rdy));
      chk("busy", i, 32'(busy_w[i]), 32'(bsy));
      chk("done", i, 32'(done_w[i]), 32'(dn));
      chk("d_out", i, 32'(d_out_w[i]), 32'(m_d[i]));
      chk("s_out", i, 32'(s_out_w[i]), 32'(m_h2));
      if (reg_en_w[i] === 1'b1 && ctrl_w[i][0] === 1'b1) begin
        strobes[i]++;
        last_code[i] = ctrl_w[i];
      end
      if (done_w[i] === 1'b1) done_cyc[i] = cyc;
      pc_ctrl[i] = ctrl_w[i];
      pc_en[i]   = reg_en_w[i];
      pc_d[i]    = d_out_w[i];
      pc_s[i]    = s_out_w[i];
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < ND; i++) begin
      strobes[i] = 0; last_code[i] = 2'b00; done_cyc[i] = -1;
    end
  endtask

  task automatic send(input logic [7:0] data, input logic d, input logic [3:0] n);
    in_data = data; dir = d; nbits = n; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2]) && k < budget) begin
      step();
      k++;
    end
    if (m_busy[0] || m_busy[1] || m_busy[2]) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  typedef struct {
    logic [3:0] n;
    logic       d;
    logic [7:0] data;
    int         exp_strobes;
    logic [1:0] exp_code;
    logic [7:0] exp_reg;   // downstream value with SER_IN held 0
  } vec_t;

  vec_t tbl[8];
  int   a;

  // ---------------- test ----------------
  initial begin
    tbl[0] = '{4'd0,  1'b0, 8'hA5, 8, 2'b01, 8'h00};
    tbl[1] = '{4'd15, 1'b1, 8'hA5, 8, 2'b11, 8'h00};
    tbl[2] = '{4'd1,  1'b0, 8'hA5, 1, 2'b01, 8'h4A};
    tbl[3] = '{4'd3,  1'b1, 8'hA5, 3, 2'b11, 8'h14};
    tbl[4] = '{4'd8,  1'b0, 8'h3C, 8, 2'b01, 8'h00};
    tbl[5] = '{4'd9,  1'b1, 8'hFF, 8, 2'b11, 8'h00};
    tbl[6] = '{4'd4,  1'b0, 8'h0F, 4, 2'b01, 8'hF0};
    tbl[7] = '{4'd7,  1'b1, 8'h80, 7, 2'b11, 8'h01};

    for (int i = 0; i < ND; i++) begin
      pc_en[i] = 1'b0; pc_ctrl[i] = 2'b00; pc_d[i] = 8'h00; pc_s[i] = 1'b0;
      dreg[i] = 8'h00;
    end
    clear_stats();

    // Reset, with IN_VALID coincident: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; dir = 1'b0; nbits = 4'd2; ser_in = 1'b0;
    repeat (3) step();
    for (int i = 0; i < ND; i++) chk("reset_busy", i, 32'(busy_w[i]), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) step();

    // DIV=4, 0xA5 shifted MSB<LSB eight times with SER_IN=0.
    clear_stats();
    send(8'hA5, 1'b0, 4'd8);
    a = cyc;
    run_until_idle(100);
    chk("a5_strobes", 0, 32'(strobes[0]), 32'd8);
    chk("a5_code", 0, 32'(last_code[0]), 32'd1);
    chk("a5_reg", 0, 32'(dreg[0]), 32'h00);
    // The accept cycle is cycle 1 (cyc a-1), so DONE in cycle 35 is cyc a+33.
    chk("a5_done_cyc", 0, 32'(done_cyc[0] - a), 32'd33);

    // DIV=1, 0x81 shifted MSB>LSB three times with SER_IN=1.
    ser_in = 1'b1;
    repeat (3) step();
    clear_stats();
    send(8'h81, 1'b1, 4'd3);
    a = cyc;
    run_until_idle(100);
    chk("x81_strobes", 1, 32'(strobes[1]), 32'd3);
    chk("x81_reg", 1, 32'(dreg[1]), 32'hF0);
    chk("x81_done_cyc", 1, 32'(done_cyc[1] - a), 32'd4);

    // Table: clamping of NBITS, both directions, end-to-end register value.
    ser_in = 1'b0;
    repeat (3) step();
    for (int v = 0; v < 8; v++) begin
      clear_stats();
      send(tbl[v].data, tbl[v].d, tbl[v].n);
      run_until_idle(100);
      for (int i = 0; i < ND; i++) begin
        chk("tbl_strobes", i, 32'(strobes[i]), 32'(tbl[v].exp_strobes));
        chk("tbl_code", i, 32'(last_code[i]), 32'(tbl[v].exp_code));
        chk("tbl_reg", i, 32'(dreg[i]), 32'(tbl[v].exp_reg));
      end
    end

    // IN_VALID held high: DIV=2, NBITS=4 re-accepts every 4*2+3 cycles.
    acc2.delete();
    in_data = 8'h5C; dir = 1'b0; nbits = 4'd4; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (busy_w[2] === 1'b0) acc2.push_back(cyc);
      step();
    end
    in_valid = 1'b0;
    chk("hold_accepts", 2, 32'(acc2.size()), 32'd4);
    for (int k = 1; k < acc2.size(); k++) begin
      chk("hold_spacing", 2, 32'(acc2[k] - acc2[k-1]), 32'd11);
    end
    run_until_idle(100);

    // Reset after the second strobe aborts; a new word follows at once.
    clear_stats();
    send(8'h5A, 1'b0, 4'd8);
    for (int k = 0; k < 20 && strobes[0] < 2; k++) step();
    chk("abort_strobes_seen", 0, 32'(strobes[0]), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("abort_ctrl", 0, 32'(ctrl_w[0]), 32'd0);
    chk("abort_d_out", 0, 32'(d_out_w[0]), 32'd0);
    send(8'h33, 1'b1, 4'd2);
    chk("abort_reaccept", 0, 32'(busy_w[0]), 32'd1);
    chk("abort_no_done", 0, 32'(done_cyc[0]), 32'hFFFF_FFFF);
    run_until_idle(100);

    // Randomised traffic, occasional resets, random serial line.
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      dir      = 1'($urandom_range(0, 1));
      nbits    = 4'($urandom_range(0, 15));
      ser_in   = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    run_until_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_shift_seq.md
REG_SHIFT_SEQ -- requirements
Module: reg_shift_seq

Interface
REQ-001 Parameter: WIDTH, default 8, width of the data word and of the driven shift register.
REQ-002 Parameter: DIV, default 4, clocks per shift strobe; legal range 1..255.
REQ-003 CLOCK  in  1  clock; all state changes on the rising edge.
REQ-004 RESET  in  1  reset; synchronous, active-high.
REQ-005 IN_DATA  in  WIDTH  word to load into the downstream shift register.
REQ-006 IN_VALID  in  1  IN_DATA/DIR/NBITS are valid.
REQ-007 IN_READY  out  1  block accepts a word this cycle.
REQ-008 DIR  in  1  shift direction: 0 = MSB<LSB (CTRL 01), 1 = MSB>LSB (CTRL 11).
REQ-009 NBITS  in  4  number of shifts after the load; 0 and values above WIDTH mean WIDTH.
REQ-010 SER_IN  in  1  asynchronous external serial line.
REQ-011 CTRL  out  2  mode code to the register: 00 hold, 01 shift MSB<LSB, 10 parallel load, 11 shift MSB>LSB.
REQ-012 D_OUT  out  WIDTH  parallel-load word to the register.
REQ-013 S_OUT  out  1  serial-in bit to the register.
REQ-014 REG_EN  out  1  clock enable to the register.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 DONE  out  1  one-cycle pulse when a sequence completes.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT and FIN; all outputs SHALL be decoded from registered state only.
REQ-018 IDLE: IN_READY=1, CTRL=00, REG_EN=0; when IN_VALID=1 at an edge, IN_DATA, DIR and NBITS (clamped) SHALL be latched and the FSM SHALL go to LOAD.
REQ-019 IN_READY SHALL be 0 in LOAD, SHIFT and FIN; IN_VALID in those states SHALL be ignored and nothing latched.
REQ-020 LOAD: lasts exactly one cycle; CTRL=10, REG_EN=1, D_OUT=latched word; next state SHIFT with the prescaler and bit counter cleared.
REQ-021 SHIFT: the prescaler SHALL count 0..DIV-1 and wrap; a strobe cycle SHALL occur when the prescaler equals DIV-1.
REQ-022 In a strobe cycle: CTRL=01 (DIR=0) or 11 (DIR=1), REG_EN=1, and the bit counter SHALL increment; in non-strobe SHIFT cycles CTRL=00 and REG_EN=0.
REQ-023 After the strobe that brings the bit counter to NBITS, the FSM SHALL go to FIN; exactly NBITS strobes SHALL be issued per sequence.
REQ-024 FIN: lasts one cycle; DONE=1, CTRL=00, REG_EN=0; next state IDLE.
REQ-025 With DIV=1, every SHIFT cycle SHALL be a strobe.
REQ-026 Timing: if the word is accepted at edge k, LOAD occupies cycle k+1, strobes occupy cycles k+1+i*DIV (i=1..NBITS), and FIN is the cycle after the last strobe.
REQ-027 The minimum cycles between accepted words SHALL be NBITS*DIV+3.
REQ-028 SER_IN SHALL pass through a two-flop synchronizer; S_OUT SHALL equal the synchronizer output at all times (two-cycle latency).
REQ-029 D_OUT SHALL hold the last latched word until the next accept.

Reset
REQ-030 While RESET=1 at an edge: state=IDLE; prescaler, bit counter, D_OUT and synchronizer flops=0; CTRL=00, REG_EN=0, DONE=0, BUSY=0, S_OUT=0.
REQ-031 Reset asserted in LOAD, SHIFT or FIN SHALL abort the sequence with no further strobes and no DONE pulse.
REQ-032 IN_VALID coincident with RESET SHALL NOT be accepted.

Verification
REQ-033 DIV=4, IN_DATA=0xA5, DIR=0, NBITS=8, SER_IN=0 -> one LOAD cycle with D_OUT=0xA5, 8 strobes with CTRL=01 spaced 4 cycles apart, DONE at cycle 35 after accept; downstream register ends at 0x00.
REQ-034 DIV=1, IN_DATA=0x81, DIR=1, NBITS=3, SER_IN=1 held -> 3 consecutive CTRL=11 cycles; register ends at 0xF0; DONE one cycle later.
REQ-035 NBITS=0 and NBITS=15 -> exactly 8 strobes each.
REQ-036 IN_VALID held high for 40 cycles, DIV=2, NBITS=4 -> words accepted only in IDLE, exactly 11 cycles apart; BUSY low only in accept cycles.
REQ-037 RESET pulsed after 2nd strobe -> all outputs at reset values next cycle, no DONE, new word accepted the cycle after RESET deasserts.
